// File: rtl/multisim_pull_dispatch.sv
// multisim_pull_dispatch
//   Round-robin dispatcher that shares one pulled valid/ready data stream
//   among NUM_REQ local consumers. It holds a single word, picks an enabled
//   consumer, and keeps that grant locked until the consumer accepts.
//
// Parameters
//   DATA_WIDTH  width of the data word
//   NUM_REQ     number of consumers (2..16)
//   IDX_W       width of the grant index (derived)
//
// Ports
//   clk        clock, all state on the rising edge
//   rst_n      asynchronous active-low reset
//   flush      synchronous drop of the held word (grant index kept)
//   up_vld     upstream word valid
//   up_rdy     dispatcher accepts the upstream word
//   up_data    upstream word
//   req_en     consumer i is eligible for the next word
//   dn_vld     one-hot: word offered to consumer i
//   dn_rdy     consumer i accepts
//   dn_data    held word, shared by all consumers
//   grant_idx  index of the current/last grant
//   busy       a word is held
//
// Optional feature (macro MULTISIM_PULL_DISPATCH_STATS_EN)
//   grant_cnt  per-consumer saturating count of accepted words
//   drop_cnt   saturating count of held words discarded by flush
module multisim_pull_dispatch #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_REQ    = 4,
  localparam int IDX_W     = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  up_vld,
  output logic                  up_rdy,
  input  logic [DATA_WIDTH-1:0] up_data,
  input  logic [NUM_REQ-1:0]    req_en,
  output logic [NUM_REQ-1:0]    dn_vld,
  input  logic [NUM_REQ-1:0]    dn_rdy,
  output logic [DATA_WIDTH-1:0] dn_data,
  output logic [IDX_W-1:0]      grant_idx,
  output logic                  busy
`ifdef MULTISIM_PULL_DISPATCH_STATS_EN
  ,
  output logic [31:0]           grant_cnt [NUM_REQ],
  output logic [31:0]           drop_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PENDING = 2'd1,
    GRANTED = 2'd2
  } state_e;

  state_e                  state_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [IDX_W-1:0]        grant_q;
  logic [NUM_REQ-1:0]      dn_vld_q;

  logic                    pick_found;
  logic [IDX_W-1:0]        pick_idx;
  logic [IDX_W-1:0]        cand_idx;
  int unsigned             cand;
  logic                    taken;

  // Round-robin search starting just after the last grant, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = grant_q;
    cand       = 0;
    cand_idx   = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand     = (32'(grant_q) + i) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!pick_found && req_en[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  // Only the granted lane's ready matters; other lanes are ignored.
  assign taken  = (state_q == GRANTED) && dn_rdy[grant_q];
  assign up_rdy = !flush && ((state_q == EMPTY) || taken);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      data_q   <= '0;
      grant_q  <= IDX_W'(NUM_REQ - 1);
      dn_vld_q <= '0;
    end else if (flush) begin
      state_q  <= EMPTY;
      dn_vld_q <= '0;
    end else begin
      case (state_q)
        EMPTY, GRANTED: begin
          if (up_vld && up_rdy) begin
            // Capture (also back-to-back after a take) and arbitrate at once.
            data_q <= up_data;
            if (pick_found) begin
              state_q  <= GRANTED;
              grant_q  <= pick_idx;
              dn_vld_q <= NUM_REQ'(1) << pick_idx;
            end else begin
              state_q  <= PENDING;
              dn_vld_q <= '0;
            end
          end else if (taken) begin
            state_q  <= EMPTY;
            dn_vld_q <= '0;
          end
        end
        PENDING: begin
          if (pick_found) begin
            state_q  <= GRANTED;
            grant_q  <= pick_idx;
            dn_vld_q <= NUM_REQ'(1) << pick_idx;
          end
        end
        default: begin
          state_q  <= EMPTY;
          dn_vld_q <= '0;
        end
      endcase
    end
  end

  assign dn_vld    = dn_vld_q;
  assign dn_data   = data_q;
  assign grant_idx = grant_q;
  assign busy      = (state_q != EMPTY);

`ifdef MULTISIM_PULL_DISPATCH_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) grant_cnt[i] <= '0;
      drop_cnt <= '0;
    end else begin
      // A word offered in a flush cycle is dropped, not delivered.
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!flush && dn_vld_q[i] && dn_rdy[i] && (grant_cnt[i] != '1))
          grant_cnt[i] <= grant_cnt[i] + 32'd1;
      end
      if (flush && (state_q != EMPTY) && (drop_cnt != '1))
        drop_cnt <= drop_cnt + 32'd1;
    end
  end
`endif

  a_up_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (up_vld && !up_rdy) |=> (up_vld && $stable(up_data)));

  a_dn_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(dn_vld));

endmodule

// File: tb/tb_multisim_pull_dispatch.sv
module tb_multisim_pull_dispatch;
  localparam int DW = 64;
  localparam int NR = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          up_vld;
  logic          up_rdy;
  logic [DW-1:0] up_data;
  logic [NR-1:0] req_en;
  logic [NR-1:0] dn_vld;
  logic [NR-1:0] dn_rdy;
  logic [DW-1:0] dn_data;
  logic [IW-1:0] grant_idx;
  logic          busy;
`ifdef MULTISIM_PULL_DISPATCH_STATS_EN
  logic [31:0]   grant_cnt [NR];
  logic [31:0]   drop_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  multisim_pull_dispatch #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .up_vld(up_vld), .up_rdy(up_rdy), .up_data(up_data),
    .req_en(req_en), .dn_vld(dn_vld), .dn_rdy(dn_rdy), .dn_data(dn_data),
    .grant_idx(grant_idx), .busy(busy)
`ifdef MULTISIM_PULL_DISPATCH_STATS_EN
    , .grant_cnt(grant_cnt), .drop_cnt(drop_cnt)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; up_vld = 1'b1; up_data = 64'hA5;
    req_en = 4'b1111; dn_rdy = 4'b0000;

    // Reset state with upstream already valid
    @(negedge clk); #1;
    check("rst_dn_vld", 64'(dn_vld), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_dn_data", dn_data, 0);
    check("rst_grant", 64'(grant_idx), 3);
    @(negedge clk); rst_n = 1'b1; #1;
    check("rel_up_rdy", 64'(up_rdy), 1);
    @(negedge clk); up_vld = 1'b0; #1;
    check("first_dn_vld", 64'(dn_vld), 4'b0001);
    check("first_dn_data", dn_data, 64'hA5);
    check("first_grant", 64'(grant_idx), 0);
    check("first_busy", 64'(busy), 1);

    // Reset while a word is held
    rst_n = 1'b0; #1;
    check("midrst_dn_vld", 64'(dn_vld), 0);
    check("midrst_busy", 64'(busy), 0);
    check("midrst_data", dn_data, 0);
    check("midrst_grant", 64'(grant_idx), 3);
    @(negedge clk); rst_n = 1'b1; dn_rdy = 4'b1111;

    // Back-to-back stream, all lanes enabled and ready
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); up_vld = 1'b1; up_data = 64'(32'h10 + k); #1;
      check("b2b_up_rdy", 64'(up_rdy), 1);
      if (k > 0) begin
        check("b2b_dn_vld", 64'(dn_vld), 64'(4'b0001 << ((k - 1) % 4)));
        check("b2b_dn_data", dn_data, 64'(32'h10 + k - 1));
      end
    end
    @(negedge clk); up_vld = 1'b0; #1;
    check("b2b_last_vld", 64'(dn_vld), 4'b1000);
    check("b2b_last_data", dn_data, 64'h17);
    @(negedge clk); dn_rdy = 4'b0000; #1;
    check("b2b_idle_busy", 64'(busy), 0);

    // No eligible consumer: word waits in PENDING
    @(negedge clk); req_en = 4'b0000; up_vld = 1'b1; up_data = 64'h55; #1;
    check("pend_up_rdy_in", 64'(up_rdy), 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); up_vld = 1'b0; #1;
      check("pend_dn_vld", 64'(dn_vld), 0);
      check("pend_up_rdy", 64'(up_rdy), 0);
      check("pend_busy", 64'(busy), 1);
    end
    @(negedge clk); req_en = 4'b0100; #1;
    check("pend_still_vld", 64'(dn_vld), 0);
    @(negedge clk); #1;
    check("pend_gr_vld", 64'(dn_vld), 4'b0100);
    check("pend_gr_data", dn_data, 64'h55);
    check("pend_gr_idx", 64'(grant_idx), 2);
    dn_rdy = 4'b0100;
    @(negedge clk); dn_rdy = 4'b0000; #1;
    check("pend_done_busy", 64'(busy), 0);

    // Locked grant: req_en[1] drops and another lane asserts ready
    @(negedge clk); req_en = 4'b0010; up_vld = 1'b1; up_data = 64'h77; #1;
    check("lock_up_rdy_in", 64'(up_rdy), 1);
    @(negedge clk); up_vld = 1'b0; req_en = 4'b0001; dn_rdy = 4'b0001; #1;
    check("lock_grant", 64'(grant_idx), 1);
    check("lock_up_rdy", 64'(up_rdy), 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      check("lock_dn_vld", 64'(dn_vld), 4'b0010);
      check("lock_dn_data", dn_data, 64'h77);
    end
    @(negedge clk); dn_rdy = 4'b0010; #1;
    check("lock_rel_up_rdy", 64'(up_rdy), 1);
    check("lock_rel_vld", 64'(dn_vld), 4'b0010);
    @(negedge clk); dn_rdy = 4'b0000; #1;
    check("lock_done_vld", 64'(dn_vld), 0);
    check("lock_done_busy", 64'(busy), 0);

    // Flush drops the held word and blocks capture in the flush cycle
    @(negedge clk); req_en = 4'b0100; up_vld = 1'b1; up_data = 64'h99; #1;
    check("fl_up_rdy_in", 64'(up_rdy), 1);
    @(negedge clk); up_vld = 1'b0; #1;
    check("fl_held_vld", 64'(dn_vld), 4'b0100);
    check("fl_held_data", dn_data, 64'h99);
    @(negedge clk); flush = 1'b1; up_vld = 1'b1; up_data = 64'hAB; #1;
    check("fl_up_rdy", 64'(up_rdy), 0);
    @(negedge clk); flush = 1'b0; #1;
    check("fl_dn_vld", 64'(dn_vld), 0);
    check("fl_busy", 64'(busy), 0);
    check("fl_grant", 64'(grant_idx), 2);
    check("fl_data_kept", dn_data, 64'h99);
    check("fl_after_up_rdy", 64'(up_rdy), 1);
`ifdef MULTISIM_PULL_DISPATCH_STATS_EN
    check("fl_drop_cnt", 64'(drop_cnt), 1);
`endif
    @(negedge clk); up_vld = 1'b0; #1;
    check("fl_next_vld", 64'(dn_vld), 4'b0100);
    check("fl_next_data", dn_data, 64'hAB);
    dn_rdy = 4'b0100;
    @(negedge clk); dn_rdy = 4'b0000; #1;
    check("fl_next_busy", 64'(busy), 0);

    // Two eligible lanes alternate; counters start from a fresh reset
    rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1; req_en = 4'b1010; dn_rdy = 4'b1111;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); up_vld = 1'b1; up_data = 64'(32'h20 + k); #1;
      check("alt_up_rdy", 64'(up_rdy), 1);
      if (k > 0) begin
        check("alt_dn_vld", 64'(dn_vld), ((k - 1) % 2 == 0) ? 4'b0010 : 4'b1000);
        check("alt_dn_data", dn_data, 64'(32'h20 + k - 1));
      end
    end
    @(negedge clk); up_vld = 1'b0; #1;
    check("alt_last_vld", 64'(dn_vld), 4'b1000);
    check("alt_last_data", dn_data, 64'h29);
    @(negedge clk); dn_rdy = 4'b0000; #1;
    check("alt_busy", 64'(busy), 0);
`ifdef MULTISIM_PULL_DISPATCH_STATS_EN
    check("cnt0", 64'(grant_cnt[0]), 0);
    check("cnt1", 64'(grant_cnt[1]), 5);
    check("cnt2", 64'(grant_cnt[2]), 0);
    check("cnt3", 64'(grant_cnt[3]), 5);
    check("drop_after_rst", 64'(drop_cnt), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
